// File: rtl/ifetch_unit.sv
// Instruction fetch stage: drives the instruction memory, fills the IF/ID register and
// parks a response that arrives during a stall in a one-entry skid buffer.
module ifetch_unit (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] cpc,
   input  logic [31:0] npc,
   output logic        pcEn,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        ihit,
   input  logic [31:0] iload,
   input  logic        stall,
   input  logic        flush,
   input  logic        halt,
   output logic [31:0] instr_out,
   output logic [31:0] pipe_npc,
   output logic        valid_out,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [31:0] r_instr;
   logic [31:0] r_pipe_npc;
   logic        r_valid;
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_buf_instr;
   logic [31:0] r_buf_npc;

   logic        w_ifid_we;
   logic [31:0] w_ifid_instr;
   logic [31:0] w_ifid_npc;
   logic        w_valid_next;
   logic        w_cnt_inc;
   logic        w_buf_we;
   logic        w_buf_clr;

   // Next-state, PC enable, memory request and IF/ID load controls.
   always_comb begin
      w_state_next = r_state;
      pcEn         = 1'b0;
      iREN         = 1'b0;
      w_ifid_we    = 1'b0;
      w_ifid_instr = r_instr;
      w_ifid_npc   = r_pipe_npc;
      w_valid_next = r_valid;
      w_cnt_inc    = 1'b0;
      w_buf_we     = 1'b0;
      w_buf_clr    = 1'b0;

      if (nRST) begin
         case (r_state)
            FETCH: begin
               iREN = 1'b1;
               if (flush) begin
                  w_ifid_we    = 1'b1;
                  w_ifid_instr = 32'h0;
                  w_ifid_npc   = 32'h0;
                  w_valid_next = 1'b0;
                  w_buf_clr    = 1'b1;
                  pcEn         = 1'b1;
               end else if (halt) begin
                  w_state_next = HALTED;
                  w_buf_clr    = 1'b1;
               end else if (ihit && !stall) begin
                  w_ifid_we    = 1'b1;
                  w_ifid_instr = iload;
                  w_ifid_npc   = npc;
                  w_valid_next = 1'b1;
                  w_cnt_inc    = 1'b1;
                  pcEn         = 1'b1;
               end else if (ihit) begin
                  w_buf_we     = 1'b1;
                  w_state_next = HOLD;
               end else if (!stall) begin
                  // No response and nothing holding us: insert a bubble.
                  w_valid_next = 1'b0;
               end
            end
            HOLD: begin
               if (flush) begin
                  w_ifid_we    = 1'b1;
                  w_ifid_instr = 32'h0;
                  w_ifid_npc   = 32'h0;
                  w_valid_next = 1'b0;
                  w_buf_clr    = 1'b1;
                  pcEn         = 1'b1;
                  w_state_next = FETCH;
               end else if (halt) begin
                  w_state_next = HALTED;
                  w_buf_clr    = 1'b1;
               end else if (!stall) begin
                  w_ifid_we    = 1'b1;
                  w_ifid_instr = r_buf_instr;
                  w_ifid_npc   = r_buf_npc;
                  w_valid_next = 1'b1;
                  w_cnt_inc    = 1'b1;
                  w_buf_clr    = 1'b1;
                  pcEn         = 1'b1;
                  w_state_next = FETCH;
               end
            end
            HALTED: begin
               w_state_next = HALTED;
            end
            default: begin
               w_state_next = FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state     <= FETCH;
         r_instr     <= 32'h0;
         r_pipe_npc  <= 32'h0;
         r_valid     <= 1'b0;
         r_fetch_cnt <= 32'h0;
         r_buf_instr <= 32'h0;
         r_buf_npc   <= 32'h0;
      end else begin
         r_state <= w_state_next;
         r_valid <= w_valid_next;
         if (w_ifid_we) begin
            r_instr    <= w_ifid_instr;
            r_pipe_npc <= w_ifid_npc;
         end
         if (w_cnt_inc) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (w_buf_we) begin
            r_buf_instr <= iload;
            r_buf_npc   <= npc;
         end else if (w_buf_clr) begin
            r_buf_instr <= 32'h0;
            r_buf_npc   <= 32'h0;
         end
      end
   end

   assign iaddr     = cpc;
   assign instr_out = r_instr;
   assign pipe_npc  = r_pipe_npc;
   assign valid_out = r_valid;
   assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, delivery, stall/skid, flush, halt, counter wrap.
module tb_ifetch_unit;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] cpc;
   logic [31:0] npc;
   logic        pcEn;
   logic        iREN;
   logic [31:0] iaddr;
   logic        ihit;
   logic [31:0] iload;
   logic        stall;
   logic        flush;
   logic        halt;
   logic [31:0] instr_out;
   logic [31:0] pipe_npc;
   logic        valid_out;
   logic [31:0] fetch_cnt;

   int n_checks = 0;
   int n_errors = 0;

   ifetch_unit dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .cpc       (cpc),
      .npc       (npc),
      .pcEn      (pcEn),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .ihit      (ihit),
      .iload     (iload),
      .stall     (stall),
      .flush     (flush),
      .halt      (halt),
      .instr_out (instr_out),
      .pipe_npc  (pipe_npc),
      .valid_out (valid_out),
      .fetch_cnt (fetch_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      nRST = 1'b0; cpc = 32'h0; npc = 32'h4; ihit = 1'b0; iload = 32'h0;
      stall = 1'b0; flush = 1'b0; halt = 1'b0;
      tick();
      tick();
      chk("reset_pcEn", {31'h0, pcEn}, 32'h0);
      chk("reset_instr", instr_out, 32'h0);
      chk("reset_npc", pipe_npc, 32'h0);
      chk("reset_valid", {31'h0, valid_out}, 32'h0);
      chk("reset_cnt", fetch_cnt, 32'h0);

      // First fetch after reset release.
      nRST = 1'b1; cpc = 32'h0; npc = 32'h4; ihit = 1'b1; iload = 32'h20010005;
      settle();
      chk("first_iREN", {31'h0, iREN}, 32'h1);
      chk("first_pcEn", {31'h0, pcEn}, 32'h1);
      chk("first_iaddr", iaddr, 32'h0);
      tick();
      chk("first_instr", instr_out, 32'h20010005);
      chk("first_npc", pipe_npc, 32'h4);
      chk("first_valid", {31'h0, valid_out}, 32'h1);
      chk("first_cnt", fetch_cnt, 32'h1);

      // Five miss cycles: bubbles, no PC advance, address stable.
      cpc = 32'h8; npc = 32'hC; ihit = 1'b0; iload = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("miss_pcEn", {31'h0, pcEn}, 32'h0);
         chk("miss_iaddr", iaddr, 32'h8);
         tick();
         chk("miss_valid", {31'h0, valid_out}, 32'h0);
      end
      chk("miss_cnt", fetch_cnt, 32'h1);

      // Hit under stall goes to the skid buffer; stall held three cycles.
      cpc = 32'h10; npc = 32'h14; ihit = 1'b1; iload = 32'h8C220000; stall = 1'b1;
      settle();
      chk("skid_pcEn", {31'h0, pcEn}, 32'h0);
      chk("skid_iREN", {31'h0, iREN}, 32'h1);
      tick();
      ihit = 1'b0; iload = 32'h12345678; npc = 32'h99;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("hold_iREN", {31'h0, iREN}, 32'h0);
         chk("hold_pcEn", {31'h0, pcEn}, 32'h0);
         tick();
         chk("hold_instr", instr_out, 32'h20010005);
         chk("hold_valid", {31'h0, valid_out}, 32'h0);
      end
      stall = 1'b0;
      settle();
      chk("release_pcEn", {31'h0, pcEn}, 32'h1);
      chk("release_iREN", {31'h0, iREN}, 32'h0);
      tick();
      chk("release_instr", instr_out, 32'h8C220000);
      chk("release_npc", pipe_npc, 32'h14);
      chk("release_valid", {31'h0, valid_out}, 32'h1);
      chk("release_cnt", fetch_cnt, 32'h2);

      // Buffered word squashed by a flush that coincides with stall.
      cpc = 32'h14; npc = 32'h18; ihit = 1'b1; iload = 32'hAAAA5555; stall = 1'b1;
      tick();
      ihit = 1'b0; flush = 1'b1;
      settle();
      chk("hflush_pcEn", {31'h0, pcEn}, 32'h1);
      tick();
      chk("hflush_instr", instr_out, 32'h0);
      chk("hflush_npc", pipe_npc, 32'h0);
      chk("hflush_valid", {31'h0, valid_out}, 32'h0);
      flush = 1'b0; stall = 1'b0;
      settle();
      chk("hflush_iREN", {31'h0, iREN}, 32'h1);
      tick();
      chk("hflush_noword", instr_out, 32'h0);
      chk("hflush_cnt", fetch_cnt, 32'h2);

      // Deliver, then flush beats a simultaneous hit and halt.
      cpc = 32'h18; npc = 32'h1C; ihit = 1'b1; iload = 32'h11112222;
      tick();
      chk("deliver3_cnt", fetch_cnt, 32'h3);
      flush = 1'b1; halt = 1'b1; iload = 32'h33334444;
      settle();
      chk("fflush_pcEn", {31'h0, pcEn}, 32'h1);
      tick();
      chk("fflush_instr", instr_out, 32'h0);
      chk("fflush_valid", {31'h0, valid_out}, 32'h0);
      chk("fflush_cnt", fetch_cnt, 32'h3);
      flush = 1'b0; halt = 1'b0; ihit = 1'b0;
      settle();
      chk("fflush_iREN", {31'h0, iREN}, 32'h1);

      // Counter wrap.
      force dut.r_fetch_cnt = 32'hFFFFFFFF;
      #1;
      release dut.r_fetch_cnt;
      cpc = 32'h20; npc = 32'h24; ihit = 1'b1; iload = 32'h55556666;
      tick();
      chk("wrap_cnt", fetch_cnt, 32'h0);
      chk("wrap_instr", instr_out, 32'h55556666);
      cpc = 32'h24; npc = 32'h28; iload = 32'h9999AAAA;
      tick();
      chk("post_wrap_cnt", fetch_cnt, 32'h1);

      // Halt drops the concurrent response and freezes the stage.
      halt = 1'b1; iload = 32'h77778888; cpc = 32'h28; npc = 32'h2C;
      settle();
      chk("halt_pcEn", {31'h0, pcEn}, 32'h0);
      tick();
      chk("halt_instr", instr_out, 32'h9999AAAA);
      chk("halt_cnt", fetch_cnt, 32'h1);
      halt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         flush = 1'b1;
         settle();
         chk("halted_iREN", {31'h0, iREN}, 32'h0);
         chk("halted_pcEn", {31'h0, pcEn}, 32'h0);
         tick();
         flush = 1'b0;
         tick();
         chk("halted_cnt", fetch_cnt, 32'h1);
         chk("halted_instr", instr_out, 32'h9999AAAA);
      end

      // Only reset leaves HALTED.
      nRST = 1'b0;
      settle();
      chk("hreset_pcEn", {31'h0, pcEn}, 32'h0);
      tick();
      chk("hreset_cnt", fetch_cnt, 32'h0);
      chk("hreset_instr", instr_out, 32'h0);
      chk("hreset_valid", {31'h0, valid_out}, 32'h0);
      nRST = 1'b1; cpc = 32'h0; npc = 32'h4; iload = 32'h0BADF00D;
      settle();
      chk("hreset_iREN", {31'h0, iREN}, 32'h1);
      tick();
      chk("refetch_instr", instr_out, 32'h0BADF00D);
      chk("refetch_cnt", fetch_cnt, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: none; all datapaths are word_t (32 bits).
REQ-002 CLK  in  1  single clock, all state updates on rising edge.
REQ-003 nRST  in  1  reset, synchronous, active-low.
REQ-004 cpc  in  32  current PC from PC stage.
REQ-005 npc  in  32  cpc+4 from PC stage.
REQ-006 pcEn  out  1  PC stage load enable.
REQ-007 iREN  out  1  instruction memory read request.
REQ-008 iaddr  out  32  instruction memory address.
REQ-009 ihit  in  1  memory response valid this cycle.
REQ-010 iload  in  32  instruction word, valid when ihit=1.
REQ-011 stall  in  1  hazard unit: IF/ID must hold.
REQ-012 flush  in  1  redirect (branch/jump/JR taken): squash IF/ID.
REQ-013 halt  in  1  halt decoded downstream: stop fetching.
REQ-014 instr_out  out  32  IF/ID instruction register.
REQ-015 pipe_npc  out  32  IF/ID npc register, consumed by PC stage jump/branch targets.
REQ-016 valid_out  out  1  IF/ID entry valid.
REQ-017 fetch_cnt  out  32  count of instructions delivered into IF/ID.

Function
REQ-018 FSM states FETCH, HOLD, HALTED; all state and output registers update only on rising CLK.
REQ-019 iREN = 1 only in FETCH; iaddr = cpc in every state.
REQ-020 Event priority, highest first: reset, flush, halt, stall.
REQ-021 FETCH, ihit=1, stall=0: IF/ID <= {iload, npc}, valid_out <= 1, pcEn = 1, fetch_cnt +1, stay FETCH.
REQ-022 FETCH, ihit=1, stall=1: iload/npc captured in one-entry skid buffer, IF/ID unchanged, pcEn = 0, next HOLD.
REQ-023 FETCH, ihit=0: pcEn = 0, IF/ID unchanged if stall=1, else valid_out <= 0 (bubble), stay FETCH.
REQ-024 HOLD, stall=1: iREN = 0, pcEn = 0, buffer and IF/ID held.
REQ-025 HOLD, stall=0: IF/ID <= buffer, valid_out <= 1, pcEn = 1, fetch_cnt +1, next FETCH.
REQ-026 flush (any state except HALTED): IF/ID <= {0, 0}, valid_out <= 0, buffer discarded, pcEn = 1 (PC loads redirect target), next FETCH; overrides ihit, stall and halt in the same cycle.
REQ-027 halt, no flush: next HALTED; pcEn = 0 that cycle; a concurrent ihit response is dropped.
REQ-028 HALTED: iREN = 0, pcEn = 0, IF/ID and fetch_cnt frozen; exited only by reset.
REQ-029 pcEn is combinational from state and inputs; at most one PC advance per delivered or flushed instruction.
REQ-030 fetch_cnt wraps 0xFFFFFFFF -> 0 without flag.
REQ-031 instr_out = 0x00000000 (nop) whenever valid_out = 0 after flush or reset.

Reset
REQ-032 nRST=0 at rising edge: state <= FETCH, instr_out <= 0, pipe_npc <= 0, valid_out <= 0, buffer cleared, fetch_cnt <= 0.
REQ-033 During reset cycle pcEn = 0; iREN = 1 from the first cycle after reset release.
REQ-034 Reset asserted in HOLD or HALTED behaves identically to REQ-032; in-flight buffered word discarded.

Verification
REQ-035 Reset, cpc=0x0, ihit=1, iload=0x20010005, stall=0 -> next cycle instr_out=0x20010005, pipe_npc=0x4, valid_out=1, pcEn=1 during hit, fetch_cnt=1.
REQ-036 ihit=1 iload=0x8C220000 npc=0x14 with stall=1 for 3 cycles -> pcEn=0, iREN=0 in HOLD, IF/ID unchanged; stall drops -> instr_out=0x8C220000, pipe_npc=0x14, pcEn=1 that cycle.
REQ-037 HOLD with buffered word, flush=1 and stall=1 same cycle -> pcEn=1, valid_out=0, instr_out=0, state FETCH, buffered word never appears.
REQ-038 halt=1 with ihit=1 -> pcEn=0, HALTED; further ihit/flush pulses leave iREN=0, fetch_cnt unchanged; nRST=0 -> state FETCH, fetch_cnt=0.
REQ-039 Preload fetch_cnt path to 0xFFFFFFFF via force, deliver one instruction -> fetch_cnt=0.
REQ-040 ihit=0 for 5 cycles, stall=0 -> valid_out=0, pcEn=0, iaddr=cpc constant throughout.
